// File: rtl/exception_unit.sv
// exception_unit
// Multicycle exception sequencer placed after the main control FSM. On an
// invalid-opcode or overflow request it saves EPC/Cause, fetches the handler
// byte from a fixed vector address and pulses PCLoad with the handler PC.
// A return-from-exception request reloads the PC from the saved EPC.
// Every output is a register; nothing here is combinationally visible.

module exception_unit #(
  parameter logic [31:0] VEC_OPCODE = 32'd254,  // handler byte for invalid opcode
  parameter logic [31:0] VEC_OVF    = 32'd255,  // handler byte for overflow
  parameter int unsigned MEM_LAT    = 1         // read latency in cycles, 0..7
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        ExcReq,
  input  logic        ExcCause,
  input  logic        RfeReq,
  input  logic [31:0] PC,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemAddr,
  output logic        MemReq,
  output logic [31:0] EPC,
  output logic [31:0] Cause,
  output logic [31:0] PCOut,
  output logic        PCLoad,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEC_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  // Reload value for the wait counter; a 3-bit counter covers MEM_LAT 0..7.
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic [2:0]  cnt_next;

  logic [31:0] mem_addr_next;
  logic        mem_req_next;
  logic [31:0] epc_next;
  logic [31:0] cause_next;
  logic [31:0] pc_out_next;
  logic        pc_load_next;
  logic        busy_next;

  // The handler vector is one byte wide; upper read-data bits are don't-care.
  logic data_unused;
  assign data_unused = ^MemDataIn[31:8];

  // State, counter and all output registers; reset clears everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      MemAddr <= '0;
      MemReq  <= 1'b0;
      EPC     <= '0;
      Cause   <= '0;
      PCOut   <= '0;
      PCLoad  <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      MemAddr <= mem_addr_next;
      MemReq  <= mem_req_next;
      EPC     <= epc_next;
      Cause   <= cause_next;
      PCOut   <= pc_out_next;
      PCLoad  <= pc_load_next;
      Busy    <= busy_next;
    end
  end

  // Next-state selection; an exception outranks a simultaneous return.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ExcReq) begin
          state_next = VEC_WAIT;
        end else if (RfeReq) begin
          state_next = DONE;
        end
      end
      VEC_WAIT: begin
        if (cnt == 3'd0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the output registers; outputs hold unless a state acts.
  always_comb begin
    cnt_next      = cnt;
    mem_addr_next = MemAddr;
    mem_req_next  = MemReq;
    epc_next      = EPC;
    cause_next    = Cause;
    pc_out_next   = PCOut;
    pc_load_next  = PCLoad;
    busy_next     = Busy;
    unique case (state)
      IDLE: begin
        if (ExcReq) begin
          // PC was already advanced at fetch; EPC points at the faulting op.
          epc_next      = PC - 32'd4;
          cause_next    = {31'b0, ExcCause};
          mem_addr_next = ExcCause ? VEC_OVF : VEC_OPCODE;
          mem_req_next  = 1'b1;
          busy_next     = 1'b1;
          cnt_next      = LAT_INIT;
        end else if (RfeReq) begin
          pc_out_next  = EPC;
          pc_load_next = 1'b1;
          busy_next    = 1'b1;
        end
      end
      VEC_WAIT: begin
        if (cnt != 3'd0) begin
          cnt_next = cnt - 3'd1;
        end else begin
          pc_out_next   = {24'b0, MemDataIn[7:0]};
          pc_load_next  = 1'b1;
          mem_req_next  = 1'b0;
          mem_addr_next = '0;
        end
      end
      DONE: begin
        // Busy drops together with the single-cycle PCLoad pulse.
        pc_load_next = 1'b0;
        busy_next    = 1'b0;
      end
      default: begin
        pc_load_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// Testbench for exception_unit: two instances (MEM_LAT=1 and MEM_LAT=3) share
// all inputs. A sequence-level model predicts every output each cycle, and a
// set of hand-computed values pins both the DUTs and the model.

module tb_exception_unit;

  logic        clk;
  logic        Reset;
  logic        ExcReq;
  logic        ExcCause;
  logic        RfeReq;
  logic [31:0] PC;
  logic [31:0] MemDataIn;

  logic [31:0] a0, e0, c0, p0, a1, e1, c1, p1;
  logic        r0, l0, b0, r1, l1, b1;

  int n_cmp  = 0;
  int n_fail = 0;

  exception_unit #(.MEM_LAT(1)) dut_lat1 (
    .clk(clk), .Reset(Reset), .ExcReq(ExcReq), .ExcCause(ExcCause),
    .RfeReq(RfeReq), .PC(PC), .MemDataIn(MemDataIn),
    .MemAddr(a0), .MemReq(r0), .EPC(e0), .Cause(c0),
    .PCOut(p0), .PCLoad(l0), .Busy(b0)
  );

  exception_unit #(.MEM_LAT(3)) dut_lat3 (
    .clk(clk), .Reset(Reset), .ExcReq(ExcReq), .ExcCause(ExcCause),
    .RfeReq(RfeReq), .PC(PC), .MemDataIn(MemDataIn),
    .MemAddr(a1), .MemReq(r1), .EPC(e1), .Cause(c1),
    .PCOut(p1), .PCLoad(l1), .Busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is modelled as "a sequence in progress, N edges old".
  logic [31:0] m_addr[2], m_epc[2], m_cause[2], m_pcout[2];
  logic        m_req[2], m_load[2], m_busy[2];
  bit          m_active[2], m_exc[2];
  int          m_age[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = '0; m_epc[k] = '0; m_cause[k] = '0; m_pcout[k] = '0;
      m_req[k] = 1'b0; m_load[k] = 1'b0; m_busy[k] = 1'b0;
      m_active[k] = 1'b0; m_exc[k] = 1'b0; m_age[k] = 0;
    end
  end

  task automatic model_step(input int k, input int lat);
    if (Reset) begin
      m_addr[k] = '0; m_epc[k] = '0; m_cause[k] = '0; m_pcout[k] = '0;
      m_req[k] = 1'b0; m_load[k] = 1'b0; m_busy[k] = 1'b0;
      m_active[k] = 1'b0;
    end else if (!m_active[k]) begin
      if (ExcReq) begin
        m_epc[k]    = PC - 32'd4;
        m_cause[k]  = {31'b0, ExcCause};
        m_addr[k]   = ExcCause ? 32'd255 : 32'd254;
        m_req[k]    = 1'b1;
        m_busy[k]   = 1'b1;
        m_active[k] = 1'b1;
        m_exc[k]    = 1'b1;
        m_age[k]    = 0;
      end else if (RfeReq) begin
        m_pcout[k]  = m_epc[k];
        m_load[k]   = 1'b1;
        m_busy[k]   = 1'b1;
        m_active[k] = 1'b1;
        m_exc[k]    = 1'b0;
        m_age[k]    = 0;
      end
    end else begin
      m_age[k]++;
      // Exception: handler byte sampled lat+1 edges after acceptance,
      // sequence over one edge later. Return: over one edge after acceptance.
      if (m_exc[k] && m_age[k] == lat + 1) begin
        m_pcout[k] = MemDataIn & 32'h0000_00FF;
        m_load[k]  = 1'b1;
        m_req[k]   = 1'b0;
        m_addr[k]  = '0;
      end
      if (m_age[k] == (m_exc[k] ? lat + 2 : 1)) begin
        m_load[k]   = 1'b0;
        m_busy[k]   = 1'b0;
        m_active[k] = 1'b0;
      end
    end
  endtask

  task automatic compare(input int k, input logic [31:0] a, e, c, p,
                         input logic r, l, b);
    string pre;
    pre = $sformatf("lat%0d", (k == 0) ? 1 : 3);
    check({pre, ".MemAddr"}, a, m_addr[k]);
    check({pre, ".MemReq"},  {31'b0, r}, {31'b0, m_req[k]});
    check({pre, ".EPC"},     e, m_epc[k]);
    check({pre, ".Cause"},   c, m_cause[k]);
    check({pre, ".PCOut"},   p, m_pcout[k]);
    check({pre, ".PCLoad"},  {31'b0, l}, {31'b0, m_load[k]});
    check({pre, ".Busy"},    {31'b0, b}, {31'b0, m_busy[k]});
  endtask

  // Advance the model on each rising edge, then compare shortly after.
  always @(posedge clk) begin
    model_step(0, 1);
    model_step(1, 3);
    #1;
    compare(0, a0, e0, c0, p0, r0, l0, b0);
    compare(1, a1, e1, c1, p1, r1, l1, b1);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Literal expectation checked against both the MEM_LAT=1 DUT and its model.
  task automatic lit(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mod_v, input logic [31:0] exp);
    check(name, dut_v, exp);
    check({name, ".model"}, mod_v, exp);
  endtask

  function automatic logic [31:0] garbage();
    logic [31:0] g;
    g = $urandom();
    return (g & 32'hFFFF_FF00) | 32'h0000_00E1;
  endfunction

  initial begin
    int pulses;
    Reset = 1'b1; ExcReq = 1'b0; ExcCause = 1'b0; RfeReq = 1'b0;
    PC = '0; MemDataIn = '0;

    // Reset held for two edges.
    repeat (2) tick();
    lit("rst.EPC", e0, m_epc[0], 32'h0);
    lit("rst.Cause", c0, m_cause[0], 32'h0);
    lit("rst.MemAddr", a0, m_addr[0], 32'h0);
    lit("rst.PCOut", p0, m_pcout[0], 32'h0);
    lit("rst.MemReq", {31'b0, r0}, {31'b0, m_req[0]}, 32'h0);
    lit("rst.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h0);
    lit("rst.Busy", {31'b0, b0}, {31'b0, m_busy[0]}, 32'h0);
    check("rst.lat3.Busy", {31'b0, b1}, 32'h0);
    Reset = 1'b0;

    // Invalid opcode at PC=0x10, handler byte 0xA4.
    PC = 32'h10; ExcCause = 1'b0; ExcReq = 1'b1; MemDataIn = 32'hA4;
    tick();
    lit("opc.E0.EPC", e0, m_epc[0], 32'h0000_000C);
    lit("opc.E0.Cause", c0, m_cause[0], 32'h0);
    lit("opc.E0.MemAddr", a0, m_addr[0], 32'd254);
    lit("opc.E0.MemReq", {31'b0, r0}, {31'b0, m_req[0]}, 32'h1);
    lit("opc.E0.Busy", {31'b0, b0}, {31'b0, m_busy[0]}, 32'h1);
    ExcReq = 1'b0;
    tick();
    lit("opc.E1.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h0);
    tick();
    lit("opc.E2.PCOut", p0, m_pcout[0], 32'h0000_00A4);
    lit("opc.E2.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h1);
    lit("opc.E2.MemReq", {31'b0, r0}, {31'b0, m_req[0]}, 32'h0);
    tick();
    lit("opc.E3.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h0);
    lit("opc.E3.Busy", {31'b0, b0}, {31'b0, m_busy[0]}, 32'h0);
    repeat (2) tick();
    check("opc.lat3.PCOut", p1, 32'h0000_00A4);

    // Return from exception.
    RfeReq = 1'b1;
    tick();
    lit("rfe.PCOut", p0, m_pcout[0], 32'h0000_000C);
    lit("rfe.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h1);
    lit("rfe.Busy", {31'b0, b0}, {31'b0, m_busy[0]}, 32'h1);
    RfeReq = 1'b0;
    tick();
    lit("rfe2.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h0);
    lit("rfe2.Busy", {31'b0, b0}, {31'b0, m_busy[0]}, 32'h0);
    lit("rfe2.EPC", e0, m_epc[0], 32'h0000_000C);

    // Overflow at PC=0: EPC wraps, upper data bits discarded.
    PC = 32'h0; ExcCause = 1'b1; ExcReq = 1'b1; MemDataIn = 32'hFFFF_FF3C;
    tick();
    lit("ovf.EPC", e0, m_epc[0], 32'hFFFF_FFFC);
    lit("ovf.Cause", c0, m_cause[0], 32'h1);
    lit("ovf.MemAddr", a0, m_addr[0], 32'd255);
    ExcReq = 1'b0;
    repeat (2) tick();
    lit("ovf.PCOut", p0, m_pcout[0], 32'h0000_003C);
    lit("ovf.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h1);
    repeat (3) tick();

    // Simultaneous requests, then a second exception while busy.
    ExcCause = 1'b0; ExcReq = 1'b1; RfeReq = 1'b1; PC = 32'h100;
    MemDataIn = 32'h55;
    tick();
    lit("sim.MemAddr", a0, m_addr[0], 32'd254);
    lit("sim.MemReq", {31'b0, r0}, {31'b0, m_req[0]}, 32'h1);
    lit("sim.PCLoad", {31'b0, l0}, {31'b0, m_load[0]}, 32'h0);
    lit("sim.EPC", e0, m_epc[0], 32'h0000_00FC);
    RfeReq = 1'b0; ExcCause = 1'b1; PC = 32'h200;
    tick();
    lit("nest.Cause", c0, m_cause[0], 32'h0);
    lit("nest.EPC", e0, m_epc[0], 32'h0000_00FC);
    ExcReq = 1'b0;
    pulses = 0;
    repeat (5) begin
      tick();
      if (l0) pulses++;
    end
    check("nest.pulses", pulses, 32'd1);
    lit("nest.PCOut", p0, m_pcout[0], 32'h0000_0055);

    // MEM_LAT=3: data sampled only at E4, garbage before is ignored.
    ExcCause = 1'b0; PC = 32'h40; ExcReq = 1'b1; MemDataIn = garbage();
    tick();
    check("lat3.E0.MemReq", {31'b0, r1}, 32'h1);
    ExcReq = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      MemDataIn = garbage();
      tick();
      check($sformatf("lat3.E%0d.MemReq", i), {31'b0, r1}, 32'h1);
      check($sformatf("lat3.E%0d.PCLoad", i), {31'b0, l1}, 32'h0);
    end
    MemDataIn = 32'h1234_5677;
    tick();
    check("lat3.E4.PCLoad", {31'b0, l1}, 32'h1);
    check("lat3.E4.PCOut", p1, 32'h0000_0077);
    check("lat3.E4.MemReq", {31'b0, r1}, 32'h0);
    MemDataIn = garbage();
    tick();
    check("lat3.E5.PCLoad", {31'b0, l1}, 32'h0);
    check("lat3.E5.Busy", {31'b0, b1}, 32'h0);

    // Reset mid-sequence abandons the vector read, no PCLoad pulse.
    ExcReq = 1'b1;
    tick();
    ExcReq = 1'b0; Reset = 1'b1;
    tick();
    check("midrst.lat3.MemReq", {31'b0, r1}, 32'h0);
    check("midrst.lat3.Busy", {31'b0, b1}, 32'h0);
    check("midrst.lat3.EPC", e1, 32'h0);
    check("midrst.lat3.PCOut", p1, 32'h0);
    lit("midrst.MemAddr", a0, m_addr[0], 32'h0);
    lit("midrst.Busy", {31'b0, b0}, {31'b0, m_busy[0]}, 32'h0);
    Reset = 1'b0;
    repeat (4) begin
      tick();
      check("midrst.lat1.PCLoad", {31'b0, l0}, 32'h0);
      check("midrst.lat3.PCLoad", {31'b0, l1}, 32'h0);
    end

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      ExcReq    = ($urandom_range(0, 3) == 0);
      RfeReq    = ($urandom_range(0, 4) == 0);
      ExcCause  = $urandom_range(0, 1) == 1;
      PC        = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      MemDataIn = $urandom();
      tick();
    end

    Reset = 1'b0; ExcReq = 1'b0; RfeReq = 1'b0;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
